calc_axi_master: RTL and testbench

//  AXI4-Lite master that drives the calculator register slave (op1@0, op2@1, opcode@2, result@3).

---
 rtl/calc_axi_pkg.sv | 29 ++
 rtl/calc_axi_master_if.sv | 41 ++++
 rtl/calc_axi_watchdog.sv | 29 ++
 rtl/calc_axi_master.sv | 178 +++++++++++++++++
 tb/tb_calc_axi_master.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_axi_pkg.sv
// Shared types and constants for the calculator AXI4-Lite master.
package calc_axi_pkg;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RSP} state_t;

    localparam int unsigned RESP_W = 2;

    localparam int unsigned ADDR_OP1    = 0;
    localparam int unsigned ADDR_OP2    = 1;
    localparam int unsigned ADDR_OPCODE = 2;
    localparam int unsigned ADDR_RESULT = 3;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_NOT = 2;
    localparam int unsigned OP_SHL = 3;

    localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

    // Register address targeted by write number idx of a command.
    function automatic int unsigned wr_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADDR_OP1;
            2'd1:    return ADDR_OP2;
            default: return ADDR_OPCODE;
        endcase
    endfunction

endpackage

// File: rtl/calc_axi_master_if.sv
// AXI4-Lite bus between the calculator master and the calculator register slave.
interface calc_axi_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 8
);
    import calc_axi_pkg::*;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [RESP_W-1:0]     bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rresp;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rvalid, rresp, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rvalid, rresp, input rready
    );

endinterface

// File: rtl/calc_axi_watchdog.sv
// Handshake watchdog: cleared on load, counts while en, flags expiry after LIMIT cycles.
// Only built when CALC_MASTER_TIMEOUT_EN is defined.
`ifdef CALC_MASTER_TIMEOUT_EN
module calc_axi_watchdog #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic en,
    output logic expired_c
);
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rstn || load) begin
            count <= '0;
        end else if (en && !expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

    // A handshake on the final cycle (load) takes precedence over expiry.
    assign expired_c = en && !load && (count == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/calc_axi_master.sv
// AXI4-Lite master for the calculator slave: three operand writes, one result read per command.
// Optional per-handshake timeout enabled with CALC_MASTER_TIMEOUT_EN.
module calc_axi_master
    import calc_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_op1,
    input  logic [DATA_WIDTH-1:0] cmd_op2,
    input  logic [DATA_WIDTH-1:0] cmd_opcode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_err,
    calc_axi_master_if.master     axi
);

    state_t                state;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [DATA_WIDTH-1:0] opcode_q;
    logic                  leave_c;
    logic                  expired_c;

    // Handshake that completes the current bus phase.
    always_comb begin
        leave_c = 1'b0;
        case (state)
            AW:      leave_c = axi.awvalid && axi.awready;
            W:       leave_c = axi.wvalid && axi.wready;
            B:       leave_c = axi.bready && axi.bvalid;
            AR:      leave_c = axi.arvalid && axi.arready;
            R:       leave_c = axi.rready && axi.rvalid;
            default: leave_c = 1'b0;
        endcase
    end

`ifdef CALC_MASTER_TIMEOUT_EN
    logic wd_en_c;
    logic wd_load_c;

    assign wd_en_c   = state inside {AW, W, B, AR, R};
    assign wd_load_c = leave_c || !wd_en_c;

    calc_axi_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rstn      (rstn),
        .load      (wd_load_c),
        .en        (wd_en_c),
        .expired_c (expired_c)
    );
`else
    // Timeout disabled: never expires.
    assign expired_c = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            idx         <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            opcode_q    <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_err     <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.awaddr  <= '0;
            axi.wvalid  <= 1'b0;
            axi.wdata   <= '0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.araddr  <= '0;
            axi.rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op1_q       <= cmd_op1;
                        op2_q       <= cmd_op2;
                        opcode_q    <= cmd_opcode;
                        idx         <= '0;
                        rsp_err     <= 1'b0;
                        cmd_ready   <= 1'b0;
                        axi.awvalid <= 1'b1;
                        axi.awaddr  <= ADDR_WIDTH'(wr_addr(2'd0));
                        state       <= AW;
                    end
                end
                AW: begin
                    if (leave_c) begin
                        axi.awvalid <= 1'b0;
                        axi.wvalid  <= 1'b1;
                        case (idx)
                            2'd0:    axi.wdata <= op1_q;
                            2'd1:    axi.wdata <= op2_q;
                            default: axi.wdata <= opcode_q;
                        endcase
                        state <= W;
                    end
                end
                W: begin
                    if (leave_c) begin
                        axi.wvalid <= 1'b0;
                        axi.bready <= 1'b1;
                        state      <= B;
                    end
                end
                B: begin
                    if (leave_c) begin
                        axi.bready <= 1'b0;
                        if (axi.bresp != RESP_OKAY) rsp_err <= 1'b1;
                        if (idx < 2'd2) begin
                            idx         <= idx + 2'd1;
                            axi.awvalid <= 1'b1;
                            axi.awaddr  <= ADDR_WIDTH'(wr_addr(idx + 2'd1));
                            state       <= AW;
                        end else begin
                            axi.arvalid <= 1'b1;
                            axi.araddr  <= ADDR_WIDTH'(ADDR_RESULT);
                            state       <= AR;
                        end
                    end
                end
                AR: begin
                    if (leave_c) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= R;
                    end
                end
                R: begin
                    if (leave_c) begin
                        axi.rready <= 1'b0;
                        rsp_result <= axi.rdata;
                        if (axi.rresp) rsp_err <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A stalled handshake is abandoned and reported as an errored response.
            if (expired_c) begin
                axi.awvalid <= 1'b0;
                axi.wvalid  <= 1'b0;
                axi.bready  <= 1'b0;
                axi.arvalid <= 1'b0;
                axi.rready  <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b1;
                rsp_result  <= '0;
                state       <= RSP;
            end
        end
    end

endmodule

// File: tb/tb_calc_axi_master.sv
// Directed bench for calc_axi_master against a calculator slave model with optional random stalls.
// The timeout scenario runs only when CALC_MASTER_TIMEOUT_EN is defined.
module tb_calc_axi_master;
    import calc_axi_pkg::*;

    localparam int unsigned TO_CYC = 64;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op1;
    logic [7:0] cmd_op2;
    logic [7:0] cmd_opcode;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_err;

    calc_axi_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus ();

    calc_axi_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op1    (cmd_op1),
        .cmd_op2    (cmd_op2),
        .cmd_opcode (cmd_opcode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .axi        (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- calculator slave model ----------------
    bit         rnd_en   = 1'b0;
    bit         aw_stuck = 1'b0;
    int         err_at   = -1;
    int         wr_num   = 0;
    int         aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit         b_pend = 1'b0, r_pend = 1'b0;
    logic [1:0] wr_sel = 2'd0;
    logic [7:0] regs [4];
    int         aw_log[$];
    int         ar_log[$];

    function automatic int next_dly();
        return rnd_en ? int'($urandom_range(0, 5)) : 0;
    endfunction

    function automatic logic [7:0] calc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        case (op[1:0])
            2'(OP_ADD): return 8'(a + b);
            2'(OP_SUB): return 8'(a - b);
            2'(OP_NOT): return ~a;
            default:    return 8'(a << b);
        endcase
    endfunction

    assign bus.awready = bus.awvalid && !aw_stuck && (aw_wait >= aw_dly);
    assign bus.wready  = bus.wvalid && (w_wait >= w_dly);
    assign bus.arready = bus.arvalid && (ar_wait >= ar_dly);
    assign bus.bvalid  = b_pend && (b_wait >= b_dly);
    assign bus.rvalid  = r_pend && (r_wait >= r_dly);

    always @(posedge clk) begin
        if (!rstn) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            b_pend <= 1'b0; r_pend <= 1'b0;
            bus.bresp <= 2'b00; bus.rdata <= 8'h00; bus.rresp <= 1'b0;
        end else begin
            aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
            w_wait  <= (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
            ar_wait <= (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;
            b_wait  <= (b_pend && !bus.bvalid) ? b_wait + 1 : 0;
            r_wait  <= (r_pend && !bus.rvalid) ? r_wait + 1 : 0;
            if (bus.awvalid && bus.awready) begin
                wr_sel <= bus.awaddr[1:0];
                aw_log.push_back(int'(bus.awaddr));
                aw_dly <= next_dly();
            end
            if (bus.wvalid && bus.wready) begin
                regs[wr_sel] <= bus.wdata;
                bus.bresp    <= (wr_num == err_at) ? 2'b01 : 2'b00;
                wr_num       <= wr_num + 1;
                b_pend       <= 1'b1;
                w_dly        <= next_dly();
            end
            if (bus.bvalid && bus.bready) begin
                b_pend <= 1'b0;
                b_dly  <= next_dly();
            end
            if (bus.arvalid && bus.arready) begin
                ar_log.push_back(int'(bus.araddr));
                bus.rdata <= calc(regs[0], regs[1], regs[2]);
                bus.rresp <= 1'b0;
                r_pend    <= 1'b1;
                ar_dly    <= next_dly();
            end
            if (bus.rvalid && bus.rready) begin
                r_pend <= 1'b0;
                r_dly  <= next_dly();
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int          viol = 0;
    logic        p_ok = 1'b0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bre, p_bv, p_rre, p_rv;
    logic        p_rspv, p_rspr, p_err;
    logic [31:0] p_awaddr, p_araddr;
    logic [7:0]  p_wdata, p_res;

    wire aw_bad  = p_ok && rstn && p_awv && !p_awr && (!bus.awvalid || bus.awaddr != p_awaddr);
    wire w_bad   = p_ok && rstn && p_wv && !p_wr && (!bus.wvalid || bus.wdata != p_wdata);
    wire ar_bad  = p_ok && rstn && p_arv && !p_arr && (!bus.arvalid || bus.araddr != p_araddr);
    wire b_bad   = p_ok && rstn && p_bre && !p_bv && !bus.bready;
    wire r_bad   = p_ok && rstn && p_rre && !p_rv && !bus.rready;
    wire rsp_bad = p_ok && rstn && p_rspv && !p_rspr &&
                   (!rsp_valid || rsp_result != p_res || rsp_err != p_err);
    wire ord_bad = rstn && bus.wvalid && bus.awvalid;

    always @(posedge clk) begin
        p_ok <= rstn;
        p_awv <= bus.awvalid; p_awr <= bus.awready; p_awaddr <= bus.awaddr;
        p_wv  <= bus.wvalid;  p_wr  <= bus.wready;  p_wdata  <= bus.wdata;
        p_arv <= bus.arvalid; p_arr <= bus.arready; p_araddr <= bus.araddr;
        p_bre <= bus.bready;  p_bv  <= bus.bvalid;
        p_rre <= bus.rready;  p_rv  <= bus.rvalid;
        p_rspv <= rsp_valid;  p_rspr <= rsp_ready;  p_res <= rsp_result; p_err <= rsp_err;
        viol <= viol + int'(aw_bad) + int'(w_bad) + int'(ar_bad) + int'(b_bad)
                     + int'(r_bad) + int'(rsp_bad) + int'(ord_bad);
    end

    // ---------------- command driver ----------------
    int hold_bad = 0;

    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int hold, output logic [7:0] res, output logic e, output int lat);
        int n = 0;
        cmd_op1 = a; cmd_op2 = b; cmd_opcode = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 1000) begin
            @(posedge clk); #1; lat++;
        end
        check("rsp_seen", 32'(rsp_valid), 32'd1);
        res = rsp_result;
        e   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_result != res || rsp_err != e || cmd_ready) hold_bad++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] res;
        logic       e;
        int         lat;
        int         n;

        rstn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op1 = 8'h00; cmd_op2 = 8'h00; cmd_opcode = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_ctl", 32'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid, rsp_err}), 32'd0);
        check("rst_data", bus.awaddr | bus.araddr | 32'(bus.wdata) | 32'(rsp_result), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 1: sum with zero-wait slave
        do_cmd(8'd5, 8'd3, 8'(OP_ADD), 0, res, e, lat);
        check("sum_res", 32'(res), 32'h08);
        check("sum_err", 32'(e), 32'd0);
        check("sum_lat", 32'(lat), 32'd11);
        check("sum_idle_ready", 32'(cmd_ready), 32'd1);

        // 2: remaining opcodes back to back
        do_cmd(8'hF0, 8'h02, 8'(OP_SUB), 0, res, e, lat);
        check("sub_res", 32'(res), 32'hEE);
        check("sub_err", 32'(e), 32'd0);
        do_cmd(8'hF0, 8'h02, 8'(OP_NOT), 0, res, e, lat);
        check("not_res", 32'(res), 32'h0F);
        check("not_err", 32'(e), 32'd0);
        do_cmd(8'hF0, 8'h02, 8'(OP_SHL), 0, res, e, lat);
        check("shl_res", 32'(res), 32'hC0);
        check("shl_err", 32'(e), 32'd0);

        // 3: random backpressure on every channel
        rnd_en = 1'b1;
        aw_log.delete();
        ar_log.delete();
        do_cmd(8'h21, 8'h13, 8'(OP_ADD), 0, res, e, lat);
        check("bp_add_res", 32'(res), 32'h34);
        do_cmd(8'h21, 8'h13, 8'(OP_SUB), 0, res, e, lat);
        check("bp_sub_res", 32'(res), 32'h0E);
        check("bp_sub_err", 32'(e), 32'd0);
        check("aw_log_size", 32'(aw_log.size()), 32'd6);
        for (int i = 0; i < aw_log.size(); i++) check("aw_seq", 32'(aw_log[i]), 32'(i % 3));
        check("ar_log_size", 32'(ar_log.size()), 32'd2);
        for (int i = 0; i < ar_log.size(); i++) check("ar_seq", 32'(ar_log[i]), 32'd3);
        check("bp_protocol", 32'(viol), 32'd0);
        rnd_en = 1'b0;

        // 4: bad bresp on the second write is reported, next command is clean
        err_at = wr_num + 1;
        do_cmd(8'd1, 8'd2, 8'(OP_ADD), 0, res, e, lat);
        check("err_res", 32'(res), 32'h03);
        check("err_flag", 32'(e), 32'd1);
        err_at = -1;
        do_cmd(8'd7, 8'd2, 8'(OP_SUB), 0, res, e, lat);
        check("clean_res", 32'(res), 32'h05);
        check("clean_flag", 32'(e), 32'd0);

        // 5: response held while rsp_ready is low
        hold_bad = 0;
        do_cmd(8'd9, 8'd4, 8'(OP_ADD), 10, res, e, lat);
        check("hold_res", 32'(res), 32'h0D);
        check("hold_stable", 32'(hold_bad), 32'd0);
        check("hold_ready_after", 32'(cmd_ready), 32'd1);
        check("hold_valid_after", 32'(rsp_valid), 32'd0);

        // 6: reset in the middle of a write data phase
        cmd_op1 = 8'h11; cmd_op2 = 8'h22; cmd_opcode = 8'(OP_ADD); cmd_valid = 1'b1;
        n = 0;
        while (!bus.wvalid && n < 100) begin
            @(posedge clk); #1; n++;
            cmd_valid = 1'b0;
        end
        check("mid_in_w", 32'(bus.wvalid), 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ctl", 32'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid}), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        rstn = 1'b1;
        @(posedge clk); #1;
        do_cmd(8'hFF, 8'h01, 8'(OP_ADD), 0, res, e, lat);
        check("wrap_res", 32'(res), 32'h00);
        check("wrap_err", 32'(e), 32'd0);
        check("protocol", 32'(viol), 32'd0);

`ifdef CALC_MASTER_TIMEOUT_EN
        aw_stuck = 1'b1;
        do_cmd(8'd1, 8'd1, 8'(OP_ADD), 0, res, e, lat);
        check("to_lat", 32'(lat), 32'(TO_CYC));
        check("to_err", 32'(e), 32'd1);
        check("to_res", 32'(res), 32'h00);
        aw_stuck = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
